vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing on vga_clk (25 MHz pixel clock). Drives DrawX, DrawY and blank to the sprite/pixel generators, and accepts their 4-bit RGB back. Delays hs, vs and blank so they stay aligned with the pixel pipeline. Drives the physical VGA pins, forcing black outside the visible area.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
PIPE_DLY, 1, clocks from DrawX/DrawY to matching red_in/green_in/blue_in (1..4)
FC_W, 8, frame counter width

Ports:
vga_clk  in  1  pixel clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
red_in  in  4  pixel colour from generator, PIPE_DLY clocks after its coordinate
green_in  in  4  as above
blue_in  in  4  as above
DrawX  out  10  current horizontal count (0..799)
DrawY  out  10  current vertical count (0..524)
blank  out  1  1 = visible pixel (hc<H_VISIBLE && vc<V_VISIBLE), 0 = blanking
frame_start  out  1  one-clock pulse while hc==0 && vc==0
hs  out  1  horizontal sync, active low, pipeline-aligned
vs  out  1  vertical sync, active low, pipeline-aligned
vga_r  out  4  pin colour
vga_g  out  4  pin colour
vga_b  out  4  pin colour
frame_count  out  FC_W  completed-frame counter (see Optional Feature)

Behaviour:
- H_TOTAL = 800 and V_TOTAL = 525 are derived from the parameters. Counters hc and vc are 10-bit.
- The run flag is a register.
- Edge with reset_n=0: hc=0, vc=0, run=0. All delay stages load blank=0, hs=1, vs=1. vga_r, vga_g and vga_b load 0. frame_count loads 0.
- Edge with reset_n=1: run<=1. If run was already 1, hc increments.
  - At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 with hc==H_TOTAL-1, vc wraps to 0.
- The first clock after reset release therefore holds hc=vc=0 for exactly one extra cycle. This gives deterministic frame alignment.
- DrawX = hc and DrawY = vc (register outputs).
- blank and frame_start are decoded combinationally from hc, vc and run. Both are 0 while run==0.
- hs_raw = 0 when hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752). Otherwise 1.
- vs_raw = 0 when vc in [490,492). Otherwise 1.
- While run==0, hs_raw=vs_raw=1.
- Delay line: blank, hs_raw and vs_raw each pass through PIPE_DLY register stages.
- Output register stage:
  - hs <= hs_d and vs <= vs_d.
  - vga_r <= blank_d ? red_in : 0. Same rule for vga_g and vga_b.
- Total latency from counter value to pins is PIPE_DLY+1 clocks. Colour inputs are sampled only when blank_d==1.
- Reset mid-frame: the next edge with reset_n=0 returns everything to reset values. There are no partial sync pulses afterwards because the delay stages are cleared to inactive.

Optional Feature:
Macro: VGA_FRAME_COUNTER_EN
- Defined: frame_count increments (mod 2^FC_W) on the edge where hc==799 && vc==524 && run==1, for use in sprite animation frame selection (e.g. alternating walking frames).
- Not defined: frame_count is held constant 0. The port remains present.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants;
  - H_TOTAL and V_TOTAL;
  - a packed struct sync_t {blank, hs, vs} used by the delay line.
- One sub-module, vga_sync_delay: parameterised depth PIPE_DLY, carries sync_t, synchronous active-low reset to {0,1,1}.

Test Plan:
- Release reset, then count clocks between consecutive frame_start pulses -> exactly 420000. The first frame_start is on the first cycle after release, with DrawX=0 and DrawY=0.
- Per line, PIPE_DLY=1 -> hs low for exactly 96 clocks. hs falls 2 clocks after DrawX==656 and rises 2 clocks after DrawX==752.
- Per frame -> vs low for exactly 1600 clocks (2 lines). vs falls 2 clocks after DrawY==490 && DrawX==0.
- Drive red_in=F, green_in=3, blue_in=A constantly -> vga pins read F/3/A for exactly 640 clocks per visible line and 0 elsewhere, including all of lines 480..524.
- Assert reset_n=0 for 3 clocks at DrawX=300, DrawY=200 -> DrawX, DrawY and vga_r/g/b are 0 and hs=vs=1 by the next edge. After release, timing restarts as in the first scenario.
- With VGA_FRAME_COUNTER_EN and FC_W=2, run 5 frames -> frame_count sequence 0,1,2,3,0, changing on the edge after DrawX=799, DrawY=524. Without the macro -> frame_count stays 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 timing constants and the sync bundle carried by the delay line.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;  // 800
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;  // 525

  typedef struct packed {
    logic blank;  // 1 = visible pixel
    logic hs;     // active low
    logic vs;     // active low
  } sync_t;

  // Inactive value: blanked, both syncs deasserted.
  localparam sync_t SYNC_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_sync_delay.sv
// Purpose: delays the blank/hs/vs bundle to line up with the pixel generator pipeline.
// Latency: PIPE_DLY clocks.
// Backpressure: none; free-running, advances every clock.
// Ports: i_clk clock, i_rst_n sync active-low reset (stages -> SYNC_IDLE),
//        i_sync bundle in, o_sync bundle out after PIPE_DLY clocks.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int PIPE_DLY = 1
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  sync_t i_sync,
  output sync_t o_sync
);

  sync_t r_stage [PIPE_DLY];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PIPE_DLY; i++) r_stage[i] <= SYNC_IDLE;
    end else begin
      r_stage[0] <= i_sync;
      for (int i = 1; i < PIPE_DLY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_sync = r_stage[PIPE_DLY-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: VGA raster timing (hc/vc counters), pipeline-aligned sync and blanked pin colour.
// Latency: counter value to pins PIPE_DLY+1 clocks; DrawX/DrawY/blank/frame_start are immediate.
// Backpressure: none; free-running raster, colour inputs must arrive PIPE_DLY clocks after DrawX/DrawY.
// Ports: vga_clk, reset_n (sync active-low); red_in/green_in/blue_in colour from generator;
//        DrawX/DrawY counters, blank (1 = visible), frame_start pulse; hs/vs/vga_r/g/b pins;
//        frame_count completed frames.
// Option: define VGA_FRAME_COUNTER_EN to enable frame_count; otherwise it is tied to 0.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int PIPE_DLY  = 1,
  parameter int FC_W      = 8
) (
  input  logic            vga_clk,
  input  logic            reset_n,
  input  logic [3:0]      red_in,
  input  logic [3:0]      green_in,
  input  logic [3:0]      blue_in,
  output logic [9:0]      DrawX,
  output logic [9:0]      DrawY,
  output logic            blank,
  output logic            frame_start,
  output logic            hs,
  output logic            vs,
  output logic [3:0]      vga_r,
  output logic [3:0]      vga_g,
  output logic [3:0]      vga_b,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOT  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_BEG = H_VISIBLE + H_FRONT;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_VISIBLE + V_FRONT;
  localparam int VS_END = VS_BEG + V_SYNC;

  logic       r_run;
  logic [9:0] r_hc;
  logic [9:0] r_vc;

  logic  w_line_end;
  logic  w_frame_end;
  sync_t w_sync_raw;
  sync_t w_sync_d;

  assign w_line_end  = (r_hc == 10'(H_TOT - 1));
  assign w_frame_end = w_line_end && (r_vc == 10'(V_TOT - 1));

  // run lags reset release by one clock so hc=vc=0 is held for an extra
  // cycle; this pins the first frame_start to the first cycle after release.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_run <= 1'b0;
      r_hc  <= '0;
      r_vc  <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_line_end) begin
          r_hc <= '0;
          r_vc <= w_frame_end ? '0 : r_vc + 10'd1;
        end else begin
          r_hc <= r_hc + 10'd1;
        end
      end
    end
  end

  assign DrawX = r_hc;
  assign DrawY = r_vc;

  always_comb begin
    w_sync_raw.blank = r_run && (r_hc < 10'(H_VISIBLE)) && (r_vc < 10'(V_VISIBLE));
    w_sync_raw.hs    = !(r_run && (r_hc >= 10'(HS_BEG)) && (r_hc < 10'(HS_END)));
    w_sync_raw.vs    = !(r_run && (r_vc >= 10'(VS_BEG)) && (r_vc < 10'(VS_END)));
  end

  assign blank       = w_sync_raw.blank;
  assign frame_start = r_run && (r_hc == '0) && (r_vc == '0);

  vga_sync_delay #(
    .PIPE_DLY (PIPE_DLY)
  ) u_sync_delay (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_sync  (w_sync_raw),
    .o_sync  (w_sync_d)
  );

  // Pin register: colour is only let through for visible pixels, so the
  // generator's output during blanking never reaches the monitor.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else begin
      hs    <= w_sync_d.hs;
      vs    <= w_sync_d.vs;
      vga_r <= w_sync_d.blank ? red_in   : 4'h0;
      vga_g <= w_sync_d.blank ? green_in : 4'h0;
      vga_b <= w_sync_d.blank ? blue_in  : 4'h0;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic [FC_W-1:0] r_frame_cnt;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (r_run && w_frame_end) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign frame_count = r_frame_cnt;
`else
  assign frame_count = '0;
`endif

endmodule
